frame_buffer_scanout: RTL
=========================

// Module: frame_buffer_scanout
// PURPOSE
//  Downstream stage of the test-pattern generator. Captures its write stream (load/address/out)
//  into an on-chip frame RAM. Once a frame is complete, streams it out in raster order over a
//  valid/ready pixel interface for the display/encoder stage. Rewrites of the same address are
//  harmless: last write wins.
// PARAMETERS
//  DATA_W     16     pixel width, bits
//  ADDR_W     16     write/read address width
//  H_ACTIVE   160    pixels per line
//  V_ACTIVE   150    lines per frame; DEPTH = H_ACTIVE*V_ACTIVE = 24000 words
//  X_W        8      width of pix_x
//  Y_W        8      width of pix_y
//  CONTINUOUS 0      1 = rescan the stored frame immediately after each frame_done
// PORTS
//  clk        in   1       single clock; all logic rising-edge
//  reset      in   1       asynchronous, active-low reset
//  wr_en      in   1       write strobe (generator load)
//  wr_addr    in   ADDR_W  write address (generator address)
//  wr_data    in   DATA_W  write data (generator out)
//  pix_ready  in   1       downstream accepts pixel
//  pix_valid  out  1       pixel present
//  pix_data   out  DATA_W  pixel value
//  pix_x      out  X_W     column of pix_data
//  pix_y      out  Y_W     row of pix_data
//  pix_sof    out  1       first pixel of frame (0,0)
//  pix_eol    out  1       last pixel of a line (x = H_ACTIVE-1)
//  pix_eof    out  1       last pixel of frame
//  frame_done out  1       1-cycle pulse after the eof beat is accepted
//  wr_drop    out  1       sticky: a write with wr_addr >= DEPTH occurred
// BEHAVIOUR
//  - Reset (reset=0, async): state IDLE. All outputs 0: pix_valid, pix_data, pix_x, pix_y,
//    sof/eol/eof, frame_done, wr_drop. frame_ready=0, wr_en_d=0, skid buffer empty.
//    RAM contents are not cleared.
//  - Write port: wr_en=1 and wr_addr<DEPTH -> mem[wr_addr]<=wr_data. Writes are accepted in any
//    FSM state.
//  - Out-of-range write: ignored; sets wr_drop until the next reset.
//  - Frame complete: falling edge of wr_en (wr_en_d=1, wr_en=0) sets frame_ready.
//    frame_ready clears when the FSM leaves IDLE. A falling edge seen outside IDLE stays
//    latched and is serviced on the next IDLE.
//  - RAM: 1-cycle synchronous read, read-first. A read and write to the same address in the
//    same cycle returns the old data.
//  - FSM IDLE -> STREAM: on a cycle with frame_ready=1. That edge issues the read of addr 0.
//    The next edge loads data into the skid buffer. pix_valid therefore rises 2 cycles after
//    frame_ready is first high in IDLE.
//  - STREAM:
//    - 2-entry skid buffer. A read is issued only while (buffered + in-flight) < 2, so no data
//      is lost.
//    - With pix_ready held 1: 1 pixel/clk, no bubbles after the first.
//    - While pix_valid=1 and pix_ready=0, pix_data/x/y/flags are held stable.
//    - x/y are carried with the data. x wraps at H_ACTIVE-1 and increments y.
//  - STREAM -> DONE: when the eof beat is accepted. DONE lasts 1 cycle with frame_done=1.
//    It then goes to IDLE, or back to STREAM at addr 0 if CONTINUOUS=1.
//  - Writes during STREAM land in RAM and may appear in the current scan (no tearing
//    protection). A new wr_en fall re-arms frame_ready.
//  - Reset mid-frame: everything returns to reset values immediately, and the partial frame is
//    abandoned.
// TESTING
//  - Reset: reset=0 with random inputs -> all outputs 0. After release with no wr_en, pix_valid
//    stays 0 for 100 cycles.
//  - Generator frame: wr_en=1; addr 0..23999, each held 16 clks; data=FFFF if addr%50==0 else
//    0000; then wr_en=0. Expect:
//    - pix_valid 2 clks after frame_ready.
//    - 24000 beats: pixel0=FFFF, 1=0000, 50=FFFF, 23950=FFFF.
//    - sof only at (0,0); eol at x=159 (150 times); eof at (159,149).
//    - frame_done 1 clk after eof accepted.
//  - Backpressure: random pix_ready (50%) -> exactly 24000 accepted beats, in order, no
//    duplicates. Data/flags stable while stalled.
//  - Out-of-range: write addr 24000 data 1234 -> wr_drop=1 until reset; scanned frame unchanged.
//  - Reset mid-stream: reset=0 at beat 5000 -> pix_valid=0 in the same cycle. After release,
//    no output until the next wr_en falling edge.
//  - CONTINUOUS=1: the cycle after frame_done the FSM re-enters STREAM; the second frame is
//    identical, sof at (0,0) 2 clks later.

Source files
------------

// File: rtl/frame_buffer_scanout_if.sv
// Generator write stream and valid/ready pixel stream around the frame buffer.
// master = generator/display side, slave = the frame buffer itself.
interface frame_buffer_scanout_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int X_W    = 8,
  parameter int Y_W    = 8
);

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              pix_ready;
  logic              pix_valid;
  logic [DATA_W-1:0] pix_data;
  logic [X_W-1:0]    pix_x;
  logic [Y_W-1:0]    pix_y;
  logic              pix_sof;
  logic              pix_eol;
  logic              pix_eof;
  logic              frame_done;
  logic              wr_drop;

  modport master (
    output wr_en, wr_addr, wr_data, pix_ready,
    input  pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
           frame_done, wr_drop
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, pix_ready,
    output pix_valid, pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof,
           frame_done, wr_drop
  );

endinterface

// File: rtl/frame_buffer_scanout.sv
// Frame RAM behind the test-pattern generator: captures its write stream and replays the
// stored frame in raster order over a valid/ready pixel stream with a 2-entry skid buffer.
module frame_buffer_scanout #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int H_ACTIVE   = 160,
  parameter int V_ACTIVE   = 150,
  parameter int X_W        = 8,
  parameter int Y_W        = 8,
  parameter int CONTINUOUS = 0
) (
  input logic                   clk,
  input logic                   reset,
  frame_buffer_scanout_if.slave bus
);

  localparam int DEPTH = H_ACTIVE * V_ACTIVE;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int AE_W  = ADDR_W + 1;
  localparam logic [AE_W-1:0] DEPTH_EXT = AE_W'(DEPTH);
  localparam logic [X_W-1:0]  X_LAST    = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]  Y_LAST    = Y_W'(V_ACTIVE - 1);
  localparam bit              RESCAN    = (CONTINUOUS != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  state_t            r_state;
  logic              r_wr_en_d;
  logic              r_frame_ready;
  logic              r_wr_drop;
  logic              r_frame_done;

  logic              r_issuing;
  logic [IDX_W-1:0]  r_rd_addr;
  logic [X_W-1:0]    r_iss_x;
  logic [Y_W-1:0]    r_iss_y;

  logic              r_inflight;
  logic [X_W-1:0]    r_fl_x;
  logic [Y_W-1:0]    r_fl_y;
  logic              r_fl_sof;
  logic              r_fl_eol;
  logic              r_fl_eof;

  logic              r_v0;
  logic [DATA_W-1:0] r_d0;
  logic [X_W-1:0]    r_x0;
  logic [Y_W-1:0]    r_y0;
  logic              r_sof0;
  logic              r_eol0;
  logic              r_eof0;

  logic              r_v1;
  logic [DATA_W-1:0] r_d1;
  logic [X_W-1:0]    r_x1;
  logic [Y_W-1:0]    r_y1;
  logic              r_sof1;
  logic              r_eol1;
  logic              r_eof1;

  logic              w_fall;
  logic              w_wr_ok;
  logic              w_start;
  logic              w_pop;
  logic [1:0]        w_occ;
  logic              w_issue;
  logic [IDX_W-1:0]  w_cur_addr;
  logic [X_W-1:0]    w_cur_x;
  logic [Y_W-1:0]    w_cur_y;
  logic              w_cur_sof;
  logic              w_cur_eol;
  logic              w_cur_eof;

  assign w_fall  = r_wr_en_d & ~bus.wr_en;
  assign w_wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_EXT);
  assign w_start = ((r_state == S_IDLE) && r_frame_ready) || ((r_state == S_DONE) && RESCAN);
  assign w_pop   = r_v0 & bus.pix_ready;

  // Occupancy counts this cycle's pop so a full-rate stream never stalls on its own buffer.
  assign w_occ   = 2'(r_v0) + 2'(r_v1) + 2'(r_inflight) - 2'(w_pop);
  assign w_issue = w_start || ((r_state == S_STREAM) && r_issuing && (w_occ < 2'd2));

  assign w_cur_addr = w_start ? '0 : r_rd_addr;
  assign w_cur_x    = w_start ? '0 : r_iss_x;
  assign w_cur_y    = w_start ? '0 : r_iss_y;
  assign w_cur_sof  = (w_cur_x == '0) && (w_cur_y == '0);
  assign w_cur_eol  = (w_cur_x == X_LAST);
  assign w_cur_eof  = w_cur_eol && (w_cur_y == Y_LAST);

  // Read-first RAM: a same-cycle write to the read address is not visible until the next read.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[bus.wr_addr[IDX_W-1:0]] <= bus.wr_data;
    end
    if (w_issue) begin
      r_rd_data <= r_mem[w_cur_addr];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_wr_en_d     <= 1'b0;
      r_frame_ready <= 1'b0;
      r_wr_drop     <= 1'b0;
      r_frame_done  <= 1'b0;
      r_issuing     <= 1'b0;
      r_rd_addr     <= '0;
      r_iss_x       <= '0;
      r_iss_y       <= '0;
      r_inflight    <= 1'b0;
      r_fl_x        <= '0;
      r_fl_y        <= '0;
      r_fl_sof      <= 1'b0;
      r_fl_eol      <= 1'b0;
      r_fl_eof      <= 1'b0;
      r_v0          <= 1'b0;
      r_d0          <= '0;
      r_x0          <= '0;
      r_y0          <= '0;
      r_sof0        <= 1'b0;
      r_eol0        <= 1'b0;
      r_eof0        <= 1'b0;
      r_v1          <= 1'b0;
      r_d1          <= '0;
      r_x1          <= '0;
      r_y1          <= '0;
      r_sof1        <= 1'b0;
      r_eol1        <= 1'b0;
      r_eof1        <= 1'b0;
    end else begin
      r_wr_en_d <= bus.wr_en;
      if (bus.wr_en && !w_wr_ok) begin
        r_wr_drop <= 1'b1;
      end

      // A fall seen while busy stays latched until the FSM next sits in IDLE.
      if (w_fall) begin
        r_frame_ready <= 1'b1;
      end else if (r_state == S_IDLE) begin
        r_frame_ready <= 1'b0;
      end

      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_frame_ready) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_pop && r_eof0) begin
            r_state      <= S_DONE;
            r_frame_done <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= RESCAN ? S_STREAM : S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      r_inflight <= w_issue;
      if (w_issue) begin
        r_fl_x    <= w_cur_x;
        r_fl_y    <= w_cur_y;
        r_fl_sof  <= w_cur_sof;
        r_fl_eol  <= w_cur_eol;
        r_fl_eof  <= w_cur_eof;
        r_issuing <= !w_cur_eof;
        r_rd_addr <= w_cur_addr + IDX_W'(1);
        if (w_cur_eol) begin
          r_iss_x <= '0;
          r_iss_y <= w_cur_y + Y_W'(1);
        end else begin
          r_iss_x <= w_cur_x + X_W'(1);
          r_iss_y <= w_cur_y;
        end
      end

      // Skid buffer: entry 0 drives the pixel outputs, entry 1 catches data landing during a stall.
      if (w_pop) begin
        if (r_v1) begin
          r_d0   <= r_d1;
          r_x0   <= r_x1;
          r_y0   <= r_y1;
          r_sof0 <= r_sof1;
          r_eol0 <= r_eol1;
          r_eof0 <= r_eof1;
          r_v0   <= 1'b1;
          if (r_inflight) begin
            r_d1   <= r_rd_data;
            r_x1   <= r_fl_x;
            r_y1   <= r_fl_y;
            r_sof1 <= r_fl_sof;
            r_eol1 <= r_fl_eol;
            r_eof1 <= r_fl_eof;
          end
          r_v1 <= r_inflight;
        end else begin
          if (r_inflight) begin
            r_d0   <= r_rd_data;
            r_x0   <= r_fl_x;
            r_y0   <= r_fl_y;
            r_sof0 <= r_fl_sof;
            r_eol0 <= r_fl_eol;
            r_eof0 <= r_fl_eof;
          end
          r_v0 <= r_inflight;
        end
      end else if (r_inflight) begin
        if (!r_v0) begin
          r_d0   <= r_rd_data;
          r_x0   <= r_fl_x;
          r_y0   <= r_fl_y;
          r_sof0 <= r_fl_sof;
          r_eol0 <= r_fl_eol;
          r_eof0 <= r_fl_eof;
          r_v0   <= 1'b1;
        end else begin
          r_d1   <= r_rd_data;
          r_x1   <= r_fl_x;
          r_y1   <= r_fl_y;
          r_sof1 <= r_fl_sof;
          r_eol1 <= r_fl_eol;
          r_eof1 <= r_fl_eof;
          r_v1   <= 1'b1;
        end
      end
    end
  end

  assign bus.pix_valid  = r_v0;
  assign bus.pix_data   = r_d0;
  assign bus.pix_x      = r_x0;
  assign bus.pix_y      = r_y0;
  assign bus.pix_sof    = r_sof0;
  assign bus.pix_eol    = r_eol0;
  assign bus.pix_eof    = r_eof0;
  assign bus.frame_done = r_frame_done;
  assign bus.wr_drop    = r_wr_drop;

endmodule
